// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable full-duplex UART, TX plus oversampled RX with 3-sample majority vote
module uart_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int DIVIDER  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int BIT_CLKS = DIVIDER * OVERSAMPLE;
    localparam int TCW      = $clog2(BIT_CLKS + 1) + 1;
    localparam int DCW      = $clog2(DIVIDER + 1) + 1;
    localparam int SCW      = $clog2(OVERSAMPLE + 1) + 1;
    localparam int BCW      = $clog2(DATA_BITS + 1) + 1;
    localparam logic PAR_ODD = (PARITY == 2);

    if (DIVIDER < 1) begin : g_bad_divider
        $error("uart_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_param
        $error("uart_cfg: frame parameter outside legal range");
    end

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BCW-1:0]       tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == TCW'(BIT_CLKS - 1));
    assign tx         = tx_q;
    assign tx_busy    = (tx_state_q != TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + TCW'(1);
        end
        case (tx_state_q)
            TX_IDLE: if (tx_start) begin
                tx_state_d = TX_START;
                tx_cnt_d   = '0;
                tx_sh_d    = tx_data;
                tx_par_d   = (^tx_data) ^ PAR_ODD;
                tx_d       = 1'b0;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_idx_d   = '0;
                tx_d       = tx_sh_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
                if (tx_idx_q == BCW'(DATA_BITS - 1)) begin
                    tx_idx_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d = TX_PAR;
                        tx_d       = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_idx_d = tx_idx_q + BCW'(1);
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                end
            end
            TX_PAR: if (tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_d       = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_idx_q == BCW'(STOP_BITS - 1)) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_idx_d = tx_idx_q + BCW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DCW-1:0]       tick_q, tick_d;
    logic [SCW-1:0]       samp_q, samp_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [BCW-1:0]       rx_idx_q, rx_idx_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_parity_err_q, rx_parity_err_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 strobe, vote_now, maj;

    assign strobe   = (tick_q == DCW'(DIVIDER - 1));
    assign vote_now = strobe && (samp_q == SCW'(OVERSAMPLE / 2 + 1));
    // Third vote is the live synchronised sample taken on the deciding tick.
    assign maj      = (v0_q & v1_q) | (v0_q & rx_s2_q) | (v1_q & rx_s2_q);

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_parity_err_q;
    assign rx_frame_err  = rx_frame_err_q;

    always_comb begin
        rx_state_d      = rx_state_q;
        tick_d          = tick_q;
        samp_d          = samp_q;
        v0_d            = v0_q;
        v1_d            = v1_q;
        rx_sh_d         = rx_sh_q;
        rx_idx_d        = rx_idx_q;
        perr_d          = perr_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        rx_parity_err_d = rx_parity_err_q;
        rx_frame_err_d  = rx_frame_err_q;
        if (rx_state_q != RX_IDLE && rx_state_q != RX_BRK) begin
            if (strobe) begin
                tick_d = '0;
                samp_d = (samp_q == SCW'(OVERSAMPLE - 1)) ? '0 : samp_q + SCW'(1);
                if (samp_q == SCW'(OVERSAMPLE / 2 - 1)) v0_d = rx_s2_q;
                if (samp_q == SCW'(OVERSAMPLE / 2))     v1_d = rx_s2_q;
            end else begin
                tick_d = tick_q + DCW'(1);
            end
        end
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                tick_d     = '0;
                samp_d     = '0;
                perr_d     = 1'b0;
            end
            RX_START: if (vote_now) begin
                rx_state_d = maj ? RX_IDLE : RX_DATA;
                rx_idx_d   = '0;
            end
            RX_DATA: if (vote_now) begin
                rx_sh_d = {maj, rx_sh_q[DATA_BITS-1:1]};
                if (rx_idx_q == BCW'(DATA_BITS - 1)) begin
                    rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
                end else begin
                    rx_idx_d = rx_idx_q + BCW'(1);
                end
            end
            RX_PAR: if (vote_now) begin
                perr_d     = maj ^ (^rx_sh_q) ^ PAR_ODD;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (vote_now) begin
                rx_data_d       = rx_sh_q;
                rx_parity_err_d = (PARITY != 0) && perr_q;
                rx_frame_err_d  = !maj;
                rx_valid_d      = 1'b1;
                rx_state_d      = maj ? RX_IDLE : RX_BRK;
            end
            RX_BRK: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q      <= TX_IDLE;
            tx_cnt_q        <= '0;
            tx_idx_q        <= '0;
            tx_sh_q         <= '0;
            tx_par_q        <= 1'b0;
            tx_q            <= 1'b1;
            rx_state_q      <= RX_IDLE;
            rx_s1_q         <= 1'b1;
            rx_s2_q         <= 1'b1;
            rx_prev_q       <= 1'b1;
            tick_q          <= '0;
            samp_q          <= '0;
            v0_q            <= 1'b1;
            v1_q            <= 1'b1;
            rx_sh_q         <= '0;
            rx_idx_q        <= '0;
            perr_q          <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
            rx_frame_err_q  <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_idx_q        <= tx_idx_d;
            tx_sh_q         <= tx_sh_d;
            tx_par_q        <= tx_par_d;
            tx_q            <= tx_d;
            rx_state_q      <= rx_state_d;
            rx_s1_q         <= rx;
            rx_s2_q         <= rx_s1_q;
            rx_prev_q       <= rx_s2_q;
            tick_q          <= tick_d;
            samp_q          <= samp_d;
            v0_q            <= v0_d;
            v1_q            <= v1_d;
            rx_sh_q         <= rx_sh_d;
            rx_idx_q        <= rx_idx_d;
            perr_q          <= perr_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_parity_err_q <= rx_parity_err_d;
            rx_frame_err_q  <= rx_frame_err_d;
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed scoreboard bench for uart_cfg in 8N1, 8E1 and 7O2 framings
`timescale 1ns/1ps
module tb_uart_cfg;
    localparam int CLKF = 1_600_000;
    localparam int BAUD = 100_000;
    localparam int OS   = 16;
    localparam int BC   = 16;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic [7:0] data_a  = '0;
    logic       tx_a, busy_a;
    logic       rx_a    = 1'b1;
    logic [7:0] rxd_a;
    logic       rv_a, pe_a, fe_a;

    logic       start_b  = 1'b0;
    logic [7:0] data_b   = '0;
    logic       tx_b, busy_b;
    logic       rx_b_drv = 1'b1;
    logic       loop_b   = 1'b0;
    logic       rx_b;
    logic [7:0] rxd_b;
    logic       rv_b, pe_b, fe_b;
    assign rx_b = loop_b ? tx_b : rx_b_drv;

    logic       start_c = 1'b0;
    logic [6:0] data_c  = '0;
    logic       tx_c, busy_c;
    logic [6:0] rxd_c;
    logic       rv_c, pe_c, fe_c;

    uart_cfg #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_data(data_a), .tx(tx_a), .tx_busy(busy_a),
        .rx(rx_a), .rx_data(rxd_a), .rx_valid(rv_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a));

    uart_cfg #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_data(data_b), .tx(tx_b), .tx_busy(busy_b),
        .rx(rx_b), .rx_data(rxd_b), .rx_valid(rv_b), .rx_parity_err(pe_b), .rx_frame_err(fe_b));

    uart_cfg #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OS)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .tx_start(start_c), .tx_data(data_c), .tx(tx_c), .tx_busy(busy_c),
        .rx(tx_c), .rx_data(rxd_c), .rx_valid(rv_c), .rx_parity_err(pe_c), .rx_frame_err(fe_c));

    rec_t sb[$];
    rec_t obs_q[$];
    int   ncmp = 0;
    int   nbad = 0;
    int   vcnt_a = 0;
    int   vcnt_b = 0;
    int   vcnt_c = 0;

    always @(negedge clk) begin
        if (rv_a) begin obs_q.push_back('{0, rxd_a, pe_a, fe_a}); vcnt_a++; end
        if (rv_b) begin obs_q.push_back('{1, rxd_b, pe_b, fe_b}); vcnt_b++; end
        if (rv_c) begin obs_q.push_back('{2, {1'b0, rxd_c}, pe_c, fe_c}); vcnt_c++; end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        ncmp++;
        assert (obs_v === exp_v) else begin
            nbad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic expect_rx(input string tag, input int budget);
        rec_t e;
        rec_t o;
        int   n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_arrived"}, 32'(obs_q.size() != 0), 1);
        if (obs_q.size() != 0 && sb.size() != 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            check({tag, "_inst"}, o.inst, e.inst);
            check({tag, "_data"}, o.data, e.data);
            check({tag, "_perr"}, o.perr, e.perr);
            check({tag, "_ferr"}, o.ferr, e.ferr);
        end
    endtask

    task automatic drive_bits(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = bits[i];
            else rx_b_drv = bits[i];
            repeat (BC) @(negedge clk);
        end
    endtask

    task automatic tx_check_a(input logic [7:0] d, input string tag);
        logic [9:0] fr;
        int   busy_n = 0;
        int   bad = 0;
        logic b160 = 1'b0;
        logic b161 = 1'b1;
        fr = {1'b1, d, 1'b0};
        @(negedge clk); start_a = 1'b1; data_a = d;
        @(negedge clk); start_a = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (busy_a) busy_n++;
            if (i <= 160 && tx_a !== fr[(i - 1) / 16]) bad++;
            if (i > 160 && tx_a !== 1'b1) bad++;
            if (i <= 160 && (i % 16) == 8)
                check($sformatf("%s_bit%0d", tag, (i - 1) / 16), tx_a, fr[(i - 1) / 16]);
            if (i == 160) b160 = busy_a;
            if (i == 161) b161 = busy_a;
            if (i == 40) begin start_a = 1'b1; data_a = ~d; end
            if (i == 41) start_a = 1'b0;
            @(negedge clk);
        end
        check({tag, "_bad_cycles"}, bad, 0);
        check({tag, "_busy_cycles"}, busy_n, 160);
        check({tag, "_busy_last"}, b160, 1);
        check({tag, "_busy_fall"}, b161, 0);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_rx_data", rxd_a, 0);
        check("rst_rx_valid", rv_a, 0);
        check("rst_perr", pe_a, 0);
        check("rst_ferr", fe_a, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tx_check_a(8'hA5, "tx8n1_a5");

        loop_b = 1'b1;
        v0 = vcnt_b;
        sb.push_back('{1, 8'h3C, 1'b0, 1'b0});
        @(negedge clk); start_b = 1'b1; data_b = 8'h3C;
        @(negedge clk); start_b = 1'b0;
        repeat (151) @(negedge clk);
        check("tx8e1_parity_bit", tx_b, 0);
        expect_rx("lb8e1_3c", 400);
        repeat (40) @(negedge clk);
        check("lb8e1_one_valid", vcnt_b - v0, 1);
        loop_b = 1'b0;

        v0 = vcnt_c;
        sb.push_back('{2, 8'h55, 1'b0, 1'b0});
        @(negedge clk); start_c = 1'b1; data_c = 7'h55;
        @(negedge clk); start_c = 1'b0;
        repeat (135) @(negedge clk);
        check("tx7o2_parity_bit", tx_c, 1);
        repeat (40) @(negedge clk);
        check("tx7o2_busy_last", busy_c, 1);
        @(negedge clk);
        check("tx7o2_busy_fall", busy_c, 0);
        expect_rx("lb7o2_55", 100);
        check("lb7o2_one_valid", vcnt_c - v0, 1);

        sb.push_back('{1, 8'h01, 1'b1, 1'b0});
        drive_bits(1, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11);
        expect_rx("perr8e1_01", 100);

        v0 = vcnt_a;
        sb.push_back('{0, 8'h00, 1'b0, 1'b1});
        rx_a = 1'b0;
        repeat (30 * BC) @(negedge clk);
        check("break_one_valid", vcnt_a - v0, 1);
        expect_rx("break", 10);
        rx_a = 1'b1;
        repeat (32) @(negedge clk);
        sb.push_back('{0, 8'h42, 1'b0, 1'b0});
        drive_bits(0, 16'({1'b1, 8'h42, 1'b0}), 10);
        expect_rx("after_break_42", 100);

        v0 = vcnt_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", vcnt_a - v0, 0);
        sb.push_back('{0, 8'h81, 1'b0, 1'b0});
        drive_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10);
        expect_rx("after_glitch_81", 100);

        @(negedge clk); start_a = 1'b1; data_a = 8'hA5;
        @(negedge clk); start_a = 1'b0;
        repeat (69) @(negedge clk);
        check("pre_reset_tx_bit3", tx_a, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_tx", tx_a, 1);
        check("midreset_busy", busy_a, 0);
        check("midreset_rx_data", rxd_a, 0);
        check("midreset_rx_data_b", rxd_b, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_check_a(8'h0F, "tx8n1_0f");

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("no_extra_rx", obs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
